mem_stage_access: RTL and testbench

Memory-stage data-port controller for the pipelined MIPS core. It consumes the M-stage controls and operands produced by the EX/MEM pipeline register: load, store, ALU address and store data. It performs the access on a variable-latency request/acknowledge data-memory bus and holds the pipeline with `stallM` until the access completes. Load data is returned with a one-cycle valid strobe for the MEM/WB register.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_access_if.sv | 23 ++
 rtl/mem_stage_access.sv | 166 ++++++++++++++++
 tb/tb_mem_stage_access.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the M-stage data-port controller.
//   state_t    : access state machine encoding
//   ALIGN_MASK : byte-offset bits that must be zero for a word access
//   is_aligned : helper applying ALIGN_MASK to an address
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic is_aligned(input logic [1:0] byte_ofs);
      return (byte_ofs & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// Request/acknowledge data-memory bus.
//   master : controller side (drives memReq/memWe/memAddr/memWdata)
//   slave  : memory side (drives memAck/memRdata)
interface mem_stage_access_if #(
   parameter int DATA_W = 32
);
   logic              memReq;
   logic              memWe;
   logic [DATA_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata;
   logic              memAck;
   logic [DATA_W-1:0] memRdata;

   modport master (
      output memReq, memWe, memAddr, memWdata,
      input  memAck, memRdata
   );

   modport slave (
      input  memReq, memWe, memAddr, memWdata,
      output memAck, memRdata
   );
endinterface

// File: rtl/mem_stage_access.sv
// Memory-stage data-port controller. Issues one word access per M-stage
// load/store on a variable-latency req/ack bus and stalls the pipeline
// until the access completes.
//   clk, rst              : clock, synchronous active-high reset
//   memToRegM, memWriteM  : load / store request from the M stage
//   aluOutM, writeDataM   : byte address and store data
//   stallM                : combinational pipeline freeze
//   readDataM, readValidM : registered load result and its one-cycle strobe
//   memErr                : one-cycle pulse on misalignment, load+store, timeout
//   bus                   : data-memory bus (master side)
//
// state | meaning
// IDLE  | waiting for an op; aligned op issues, misaligned op only flags memErr
// REQ   | memReq held, bus outputs frozen, counting cycles toward TIMEOUT
// DONE  | one-cycle completion; pipeline released, next op not accepted
module mem_stage_access
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memToRegM,
   input  logic              memWriteM,
   input  logic [DATA_W-1:0] aluOutM,
   input  logic [DATA_W-1:0] writeDataM,
   output logic              stallM,
   output logic [DATA_W-1:0] readDataM,
   output logic              readValidM,
   output logic              memErr,
   mem_stage_access_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;

   logic op_valid;
   logic op_aligned;

   assign op_valid   = memToRegM | memWriteM;
   assign op_aligned = is_aligned(aluOutM[1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      stallM   = 1'b0;

      case (state_q)
         IDLE: begin
            if (op_valid) begin
               if (!op_aligned) begin
                  // Flag only; the pipeline carries on without a bus access.
                  err_d = 1'b1;
               end else begin
                  stallM  = 1'b1;
                  state_d = REQ;
                  req_d   = 1'b1;
                  we_d    = memWriteM;
                  addr_d  = {aluOutM[DATA_W-1:2], 2'b00};
                  wdata_d = writeDataM;
                  cnt_d   = '0;
                  // Load+store together is treated as a store but still flagged.
                  err_d   = memToRegM & memWriteM;
               end
            end
         end

         REQ: begin
            stallM = 1'b1;
            if (bus.memAck) begin
               req_d   = 1'b0;
               state_d = DONE;
               if (!we_q) begin
                  rdata_d  = bus.memRdata;
                  rvalid_d = 1'b1;
               end
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               // cnt_q counts completed REQ cycles, so this is the TIMEOUT-th one.
               if (cnt_q >= CNT_LAST) begin
                  req_d   = 1'b0;
                  err_d   = 1'b1;
                  state_d = DONE;
                  if (!we_q) begin
                     rdata_d  = '0;
                     rvalid_d = 1'b1;
                  end
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Inputs are not trusted while reset is held.
      if (rst) begin
         stallM = 1'b0;
      end
   end

   assign bus.memReq   = req_q;
   assign bus.memWe    = we_q;
   assign bus.memAddr  = addr_q;
   assign bus.memWdata = wdata_q;
   assign readDataM    = rdata_q;
   assign readValidM   = rvalid_q;
   assign memErr       = err_q;

endmodule

// File: tb/tb_mem_stage_access.sv
module tb_mem_stage_access;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic        memToRegM;
   logic        memWriteM;
   logic [31:0] aluOutM;
   logic [31:0] writeDataM;
   logic        stallM;
   logic [31:0] readDataM;
   logic        readValidM;
   logic        memErr;

   mem_stage_access_if #(.DATA_W(32)) bus ();

   mem_stage_access #(
      .DATA_W (32),
      .TIMEOUT(TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .memToRegM (memToRegM),
      .memWriteM (memWriteM),
      .aluOutM   (aluOutM),
      .writeDataM(writeDataM),
      .stallM    (stallM),
      .readDataM (readDataM),
      .readValidM(readValidM),
      .memErr    (memErr),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_rdata = '0;

   initial begin
      #2ms;
      $display("FAIL watchdog observed no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      memToRegM     = 1'b0;
      memWriteM     = 1'b0;
      aluOutM       = '0;
      writeDataM    = '0;
      bus.memAck    = 1'b0;
      bus.memRdata  = '0;
   endtask

   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next
   // IDLE cycle with inputs idle. ack_k = REQ cycle carrying memAck (1-based);
   // ack_k > TO means no ack at all.
   task automatic run_op(input bit ld, input bit st, input logic [31:0] addr,
                         input logic [31:0] wd, input int ack_k, input logic [31:0] rd);
      bit mis    = (addr[1:0] != 2'b00);
      bit is_ld  = ld & ~st;
      bit tmo    = (ack_k > TO);
      int n      = tmo ? TO : ack_k;
      memToRegM    = ld;
      memWriteM    = st;
      aluOutM      = addr;
      writeDataM   = wd;
      bus.memAck   = 1'b0;
      bus.memRdata = $urandom;
      @(negedge clk);
      chk("stall_t0", {31'd0, stallM}, {31'd0, !mis});
      chk("req_t0", {31'd0, bus.memReq}, 32'd0);
      if (mis) begin
         @(posedge clk); #1;
         drive_idle();
         @(negedge clk);
         chk("mis_err", {31'd0, memErr}, 32'd1);
         chk("mis_req", {31'd0, bus.memReq}, 32'd0);
         chk("mis_stall", {31'd0, stallM}, 32'd0);
         chk("mis_rvalid", {31'd0, readValidM}, 32'd0);
         chk("mis_rdata", readDataM, exp_rdata);
         @(posedge clk); #1;
      end else begin
         for (int t = 1; t <= n + 1; t++) begin
            @(posedge clk); #1;
            bus.memAck   = (!tmo && t == ack_k);
            bus.memRdata = (t == ack_k) ? rd : $urandom;
            @(negedge clk);
            if (t == n + 1 && is_ld) exp_rdata = tmo ? 32'd0 : rd;
            chk("stall", {31'd0, stallM}, {31'd0, t <= n});
            chk("req", {31'd0, bus.memReq}, {31'd0, t <= n});
            chk("err", {31'd0, memErr},
                {31'd0, (t == 1 && ld && st) || (t == n + 1 && tmo)});
            chk("rvalid", {31'd0, readValidM}, {31'd0, t == n + 1 && is_ld});
            chk("rdata", readDataM, exp_rdata);
            if (t <= n) begin
               chk("we", {31'd0, bus.memWe}, {31'd0, st});
               chk("addr", bus.memAddr, addr);
               chk("wdata", bus.memWdata, wd);
            end
         end
         @(posedge clk); #1;
         drive_idle();
      end
   endtask

   // Idle cycles, optionally with a stray memAck that must be ignored.
   task automatic idle_cycles(input int m, input bit spur);
      for (int i = 0; i < m; i++) begin
         bus.memAck   = spur;
         bus.memRdata = $urandom;
         @(negedge clk);
         chk("idle_req", {31'd0, bus.memReq}, 32'd0);
         chk("idle_stall", {31'd0, stallM}, 32'd0);
         chk("idle_err", {31'd0, memErr}, 32'd0);
         chk("idle_rvalid", {31'd0, readValidM}, 32'd0);
         chk("idle_rdata", readDataM, exp_rdata);
         @(posedge clk); #1;
         bus.memAck = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_stall", {31'd0, stallM}, 32'd0);
      chk("rst_req", {31'd0, bus.memReq}, 32'd0);
      chk("rst_rdata", readDataM, 32'd0);
      chk("rst_addr", bus.memAddr, 32'd0);
      chk("rst_err", {31'd0, memErr}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_cycles(1, 1'b0);

      // Load, ack in first REQ cycle
      run_op(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
      // Store, ack after 3 REQ cycles
      run_op(1'b0, 1'b1, 32'h204, 32'h12345678, 3, 32'hCAFEF00D);
      // Misaligned load
      run_op(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h11111111);
      // Load with no ack: timeout
      run_op(1'b1, 1'b0, 32'h40, 32'h0, 99, 32'h0);
      // Load+store together, then stray acks in IDLE
      run_op(1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 2, 32'h22222222);
      idle_cycles(3, 1'b1);
      // Back-to-back loads
      run_op(1'b1, 1'b0, 32'h500, 32'h0, 1, 32'h33333333);
      run_op(1'b1, 1'b0, 32'h504, 32'h0, 2, 32'h44444444);

      // Reset in the 2nd REQ cycle with an in-flight ack
      memToRegM  = 1'b1;
      aluOutM    = 32'h300;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rq1_req", {31'd0, bus.memReq}, 32'd1);
      @(posedge clk); #1;
      rst          = 1'b1;
      bus.memAck   = 1'b1;
      bus.memRdata = 32'h55555555;
      @(negedge clk);
      chk("rq2_stall_masked", {31'd0, stallM}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive_idle();
      exp_rdata = '0;
      @(negedge clk);
      chk("prst_req", {31'd0, bus.memReq}, 32'd0);
      chk("prst_stall", {31'd0, stallM}, 32'd0);
      chk("prst_rdata", readDataM, 32'd0);
      chk("prst_rvalid", {31'd0, readValidM}, 32'd0);
      chk("prst_err", {31'd0, memErr}, 32'd0);
      chk("prst_we", {31'd0, bus.memWe}, 32'd0);
      chk("prst_addr", bus.memAddr, 32'd0);
      chk("prst_wdata", bus.memWdata, 32'd0);
      @(posedge clk); #1;
      run_op(1'b1, 1'b0, 32'h0, 32'h0, 1, 32'h66666666);

      // Randomized ops against the cycle model in run_op
      for (int i = 0; i < 60; i++) begin
         int          kind = $urandom_range(0, 5);
         bit          ld   = (kind <= 2) || (kind == 5);
         bit          st   = (kind == 3) || (kind == 4) || (kind == 5);
         logic [31:0] a    = $urandom;
         a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_op(ld, st, a, $urandom, $urandom_range(1, TO + 2), $urandom);
         idle_cycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
